// File: rtl/lcd8080_ctrl_pkg.sv
// Shared definitions for the i8080 host bus to RGB pixel FIFO bridge:
// command codes, the synchronized bus bundle and the frame size helper.
package lcd8080_ctrl_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    typedef struct packed {
        logic       rs;
        logic       we;
        logic [7:0] data;
    } j80_bus_t;

    function automatic int frame_bytes(input int h_res, input int v_res, input int bpp);
        return h_res * v_res * bpp;
    endfunction

endpackage

// File: rtl/lcd8080_ctrl_if.sv
// i8080-style host bus: strobe, select, write enable, data byte and ready.
interface lcd8080_ctrl_if;

    logic       J80_CLK;
    logic       J80_RS;
    logic       J80_We;
    logic       J80_Re;
    logic [7:0] J80_Data;

    modport master (output J80_CLK, output J80_RS, output J80_We, output J80_Data, input J80_Re);
    modport slave  (input J80_CLK, input J80_RS, input J80_We, input J80_Data, output J80_Re);

endinterface

// File: rtl/lcd8080_ctrl_j80_sync.sv
// Two-flop synchronizer followed by a third register stage. With EDGE=1 the
// output is a one-cycle rising-edge pulse, otherwise the delayed level.
module lcd8080_ctrl_j80_sync #(
    parameter int W    = 1,
    parameter bit EDGE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;
    logic [W-1:0] s3_q, s3_d;

    // Next-state for the synchronizer chain.
    always_comb begin
        s1_d = d_i;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchronizer chain registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= {W{1'b0}};
            s2_q <= {W{1'b0}};
            s3_q <= {W{1'b0}};
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // The third stage doubles as the previous-value register for edge detect,
    // so the level output lines up in time with the edge pulse.
    generate
        if (EDGE) begin : g_edge
            logic [W-1:0] rise_q, rise_d;

            always_comb begin
                rise_d = s2_q & ~s3_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rise_q <= {W{1'b0}};
                end else begin
                    rise_q <= rise_d;
                end
            end

            assign q_o = rise_q;
        end else begin : g_level
            assign q_o = s3_q;
        end
    endgenerate

endmodule

// File: rtl/lcd8080_ctrl.sv
// i8080 host bus to RGB pixel FIFO bridge: decodes command bytes, drives the
// backlight and frame window, and forwards pixel bytes while a frame is open.
module lcd8080_ctrl
    import lcd8080_ctrl_pkg::*;
#(
    parameter int H_RES           = 800,
    parameter int V_RES           = 480,
    parameter int BYTES_PER_PIXEL = 2
) (
    input  logic               CLK,
    input  logic               nRST,
    lcd8080_ctrl_if.slave      host,
    output logic               FIFOWe,
    output logic               FIFO_WClk,
    output logic               LCD_BL,
    output logic               FrameCtrl,
    output logic [7:0]         RGBData
);

    localparam int FRAME_BYTES = frame_bytes(H_RES, V_RES, BYTES_PER_PIXEL);
    localparam int CNT_W       = $clog2(FRAME_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BYTES);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic     strobe_s;
    j80_bus_t bus_pin_s;
    j80_bus_t bus_s;

    assign bus_pin_s = {host.J80_RS, host.J80_We, host.J80_Data};

    lcd8080_ctrl_j80_sync #(.W(1), .EDGE(1'b1)) u_sync_strobe (
        .clk   (CLK),
        .rst_n (nRST),
        .d_i   (host.J80_CLK),
        .q_o   (strobe_s)
    );

    lcd8080_ctrl_j80_sync #(.W($bits(j80_bus_t)), .EDGE(1'b0)) u_sync_bus (
        .clk   (CLK),
        .rst_n (nRST),
        .d_i   (bus_pin_s),
        .q_o   (bus_s)
    );

    logic             ready_q,  ready_d;
    logic             busy_q,   busy_d;
    logic             fifowe_q, fifowe_d;
    logic             wclk_q,   wclk_d;
    logic             bl_q,     bl_d;
    logic             frame_q,  frame_d;
    logic [7:0]       rgb_q,    rgb_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    // Command decode, pixel forwarding and ready/FIFO clock sequencing.
    always_comb begin
        ready_d  = ~(strobe_s | busy_q);
        busy_d   = strobe_s;
        wclk_d   = fifowe_q;
        fifowe_d = 1'b0;
        bl_d     = bl_q;
        frame_d  = frame_q;
        rgb_d    = rgb_q;
        cnt_d    = cnt_q;
        if (strobe_s && bus_s.we) begin
            if (!bus_s.rs) begin
                frame_d = 1'b0;
                case (bus_s.data)
                    CMD_DISPON:  bl_d = 1'b1;
                    CMD_DISPOFF: bl_d = 1'b0;
                    CMD_RAMWR: begin
                        frame_d = 1'b1;
                        cnt_d   = CNT_ZERO;
                    end
                    CMD_SWRESET: begin
                        bl_d  = 1'b0;
                        cnt_d = CNT_ZERO;
                    end
                    default:     bl_d = bl_q;
                endcase
            end else if (frame_q && (cnt_q != CNT_LAST)) begin
                // The last byte of the frame closes the window on the same edge.
                fifowe_d = 1'b1;
                rgb_d    = bus_s.data;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_d == CNT_LAST) begin
                    frame_d = 1'b0;
                end else begin
                    frame_d = frame_q;
                end
            end else begin
                fifowe_d = 1'b0;
            end
        end else begin
            fifowe_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            fifowe_q <= 1'b0;
            wclk_q   <= 1'b0;
            bl_q     <= 1'b0;
            frame_q  <= 1'b0;
            rgb_q    <= 8'h00;
            cnt_q    <= CNT_ZERO;
        end else begin
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            fifowe_q <= fifowe_d;
            wclk_q   <= wclk_d;
            bl_q     <= bl_d;
            frame_q  <= frame_d;
            rgb_q    <= rgb_d;
            cnt_q    <= cnt_d;
        end
    end

    // Ready drops already in the strobe cycle, ahead of the registered busy state.
    assign host.J80_Re = ready_q & ~strobe_s;
    assign FIFOWe      = fifowe_q;
    assign FIFO_WClk   = wclk_q;
    assign LCD_BL      = bl_q;
    assign FrameCtrl   = frame_q;
    assign RGBData     = rgb_q;

endmodule

// File: tb/tb_lcd8080_ctrl.sv
// Directed bench: a full-size bridge and a 2x1-pixel bridge share one host bus.
module tb_lcd8080_ctrl;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       j80_clk = 1'b0;
    logic       j80_rs = 1'b0;
    logic       j80_we = 1'b0;
    logic [7:0] j80_data = 8'h00;

    logic [1:0] fifowe, wclk, bl, frame, re;
    logic [7:0] rgb [2];

    int checks = 0;
    int errors = 0;

    lcd8080_ctrl_if bus_a ();
    lcd8080_ctrl_if bus_b ();

    assign bus_a.J80_CLK  = j80_clk;
    assign bus_a.J80_RS   = j80_rs;
    assign bus_a.J80_We   = j80_we;
    assign bus_a.J80_Data = j80_data;
    assign bus_b.J80_CLK  = j80_clk;
    assign bus_b.J80_RS   = j80_rs;
    assign bus_b.J80_We   = j80_we;
    assign bus_b.J80_Data = j80_data;
    assign re = {bus_b.J80_Re, bus_a.J80_Re};

    lcd8080_ctrl dut_a (
        .CLK       (CLK),
        .nRST      (nRST),
        .host      (bus_a.slave),
        .FIFOWe    (fifowe[0]),
        .FIFO_WClk (wclk[0]),
        .LCD_BL    (bl[0]),
        .FrameCtrl (frame[0]),
        .RGBData   (rgb[0])
    );

    lcd8080_ctrl #(.H_RES(2), .V_RES(1), .BYTES_PER_PIXEL(2)) dut_b (
        .CLK       (CLK),
        .nRST      (nRST),
        .host      (bus_b.slave),
        .FIFOWe    (fifowe[1]),
        .FIFO_WClk (wclk[1]),
        .LCD_BL    (bl[1]),
        .FrameCtrl (frame[1]),
        .RGBData   (rgb[1])
    );

    always #5 CLK = ~CLK;

    // FIFO write log: byte and FrameCtrl at every FIFOWe, plus pulse-shape violations.
    int         we_cnt   [2] = '{0, 0};
    int         wclk_bad [2] = '{0, 0};
    logic [7:0] we_data  [2][64];
    logic       we_frame [2][64];
    logic [1:0] prev_we = 2'b00;

    always @(negedge CLK) begin
        if (nRST) begin
            for (int k = 0; k < 2; k++) begin
                if ((wclk[k] !== prev_we[k]) || (fifowe[k] && prev_we[k]))
                    wclk_bad[k] <= wclk_bad[k] + 1;
                if (fifowe[k] === 1'b1) begin
                    if (we_cnt[k] < 64) begin
                        we_data[k][we_cnt[k]]  <= rgb[k];
                        we_frame[k][we_cnt[k]] <= frame[k];
                    end
                    we_cnt[k] <= we_cnt[k] + 1;
                end
            end
            prev_we <= fifowe;
        end else begin
            prev_we <= 2'b00;
        end
    end

    task automatic strobe(input logic rs, input logic we, input logic [7:0] d);
        @(negedge CLK);
        j80_rs = rs;
        j80_we = we;
        j80_data = d;
        repeat (2) @(negedge CLK);
        j80_clk = 1'b1;
        repeat (4) @(negedge CLK);
        j80_clk = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_reset();
        #95;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({re[k], fifowe[k], wclk[k], bl[k], frame[k], rgb[k]} !== 13'h0000) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got %04h expected 0000", k,
                         {re[k], fifowe[k], wclk[k], bl[k], frame[k], rgb[k]});
            end
        end
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        checks++;
        if (re !== 2'b00) begin
            errors++;
            $display("FAIL re_at_release: got %b expected 00", re);
        end
        @(negedge CLK);
        checks++;
        if (re !== 2'b11) begin
            errors++;
            $display("FAIL re_after_first_clk: got %b expected 11", re);
        end
    endtask

    task automatic test_ignore_cmd();
        int a0 = we_cnt[0];
        int b0 = we_cnt[1];
        for (int i = 0; i < 20; i++) strobe(1'b0, 1'b1, 8'h60);
        checks++;
        if ((we_cnt[0] - a0) + (we_cnt[1] - b0) !== 0) begin
            errors++;
            $display("FIFOWe count after 0x60 FAIL: got %0d expected 0",
                     (we_cnt[0] - a0) + (we_cnt[1] - b0));
        end
        checks++;
        if ({bl, frame, rgb[0], rgb[1]} !== 20'h00000) begin
            errors++;
            $display("FAIL ignore_cmd_outputs: got %05h expected 00000", {bl, frame, rgb[0], rgb[1]});
        end
    endtask

    task automatic test_backlight();
        logic [6:0] bl_log;
        logic [6:0] re_log;
        bl_log = 7'h00;
        re_log = 7'h00;
        @(negedge CLK);
        j80_rs = 1'b0;
        j80_we = 1'b1;
        j80_data = 8'h29;
        repeat (2) @(negedge CLK);
        j80_clk = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge CLK);
            bl_log[i] = bl[0];
            re_log[i] = re[0];
        end
        j80_clk = 1'b0;
        repeat (4) @(negedge CLK);
        checks++;
        if ({bl_log[3], bl_log[4]} !== 2'b01) begin
            errors++;
            $display("FAIL bl_rise_timing: got bl@3=%b bl@4=%b expected 0 then 1", bl_log[3], bl_log[4]);
        end
        checks++;
        if ({re_log[2], re_log[3], re_log[4], re_log[5], re_log[6]} !== 5'b10001) begin
            errors++;
            $display("FAIL re_busy_window: got %b expected 10001",
                     {re_log[2], re_log[3], re_log[4], re_log[5], re_log[6]});
        end
        strobe(1'b0, 1'b1, 8'h28);
        checks++;
        if (bl !== 2'b00) begin
            errors++;
            $display("FAIL bl_off: got %b expected 00", bl);
        end
    endtask

    task automatic test_frame();
        int a0 = we_cnt[0];
        int w0 = wclk_bad[0];
        strobe(1'b0, 1'b1, 8'h2C);
        checks++;
        if (frame !== 2'b11) begin
            errors++;
            $display("FAIL frame_open: got %b expected 11", frame);
        end
        strobe(1'b1, 1'b1, 8'hA5);
        strobe(1'b1, 1'b1, 8'h3C);
        checks++;
        if (we_cnt[0] - a0 !== 2) begin
            errors++;
            $display("FAIL frame_we_count: got %0d expected 2", we_cnt[0] - a0);
        end
        checks++;
        if ({we_data[0][a0], we_data[0][a0 + 1]} !== 16'hA53C) begin
            errors++;
            $display("FAIL frame_bytes: got %04h expected a53c", {we_data[0][a0], we_data[0][a0 + 1]});
        end
        checks++;
        if (wclk_bad[0] - w0 !== 0) begin
            errors++;
            $display("FAIL wclk_follows_we: got %0d violations expected 0", wclk_bad[0] - w0);
        end
    endtask

    task automatic test_dropped();
        int a0 = we_cnt[0];
        strobe(1'b0, 1'b1, 8'h60);
        checks++;
        if (frame[0] !== 1'b0) begin
            errors++;
            $display("FAIL other_cmd_closes_frame: got %b expected 0", frame[0]);
        end
        strobe(1'b1, 1'b1, 8'h55);
        strobe(1'b0, 1'b1, 8'h29);
        strobe(1'b0, 1'b1, 8'h2C);
        strobe(1'b1, 1'b0, 8'h99);
        strobe(1'b0, 1'b0, 8'h28);
        checks++;
        if (we_cnt[0] - a0 !== 0) begin
            errors++;
            $display("FAIL dropped_we_count: got %0d expected 0", we_cnt[0] - a0);
        end
        checks++;
        if ({rgb[0], bl[0], frame[0]} !== 10'h0F3) begin
            errors++;
            $display("FAIL dropped_state: got rgb=%02h bl=%b frame=%b expected rgb=3c bl=1 frame=1",
                     rgb[0], bl[0], frame[0]);
        end
        strobe(1'b0, 1'b1, 8'h01);
        checks++;
        if ({bl, frame} !== 4'b0000) begin
            errors++;
            $display("FAIL soft_reset: got bl=%b frame=%b expected 00 00", bl, frame);
        end
    endtask

    task automatic test_frame_end();
        logic [7:0] bytes_v [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        int a0 = we_cnt[0];
        int b0 = we_cnt[1];
        int w1 = wclk_bad[1];
        strobe(1'b0, 1'b1, 8'h2C);
        for (int i = 0; i < 5; i++) strobe(1'b1, 1'b1, bytes_v[i]);
        checks++;
        if (we_cnt[1] - b0 !== 4) begin
            errors++;
            $display("FAIL small_we_count: got %0d expected 4", we_cnt[1] - b0);
        end
        checks++;
        if ({we_frame[1][b0 + 2], we_frame[1][b0 + 3], we_data[1][b0 + 3]} !== 10'h244) begin
            errors++;
            $display("FAIL frame_end_edge: got f3=%b f4=%b d4=%02h expected 1 0 44",
                     we_frame[1][b0 + 2], we_frame[1][b0 + 3], we_data[1][b0 + 3]);
        end
        checks++;
        if ({frame[1], rgb[1]} !== 9'h044) begin
            errors++;
            $display("FAIL small_after_frame: got frame=%b rgb=%02h expected 0 44", frame[1], rgb[1]);
        end
        checks++;
        if ({we_cnt[0] - a0, 31'(frame[0])} !== {32'd5, 31'd1}) begin
            errors++;
            $display("FAIL big_frame: got count=%0d frame=%b expected 5 1", we_cnt[0] - a0, frame[0]);
        end
        checks++;
        if (wclk_bad[1] - w1 !== 0) begin
            errors++;
            $display("FAIL small_wclk: got %0d violations expected 0", wclk_bad[1] - w1);
        end
        strobe(1'b0, 1'b1, 8'h2C);
        strobe(1'b1, 1'b1, 8'h66);
        checks++;
        if ({we_cnt[1] - b0, 31'(frame[1])} !== {32'd5, 31'd1}) begin
            errors++;
            $display("FAIL reopen_frame: got count=%0d frame=%b expected 5 1", we_cnt[1] - b0, frame[1]);
        end
    endtask

    task automatic test_reset_midframe();
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        checks++;
        if ({frame, fifowe, re, rgb[0], rgb[1]} !== 22'h000000) begin
            errors++;
            $display("FAIL midframe_reset: got %06h expected 000000", {frame, fifowe, re, rgb[0], rgb[1]});
        end
        @(negedge CLK);
        nRST = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_ignore_cmd();
        test_backlight();
        test_frame();
        test_dropped();
        test_frame_end();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd8080_ctrl.md
Name: lcd8080_ctrl

Overview:
Bridge from an i8080-style 8-bit parallel host bus (command/data select, write enable, write strobe) to an RGB-LCD pixel FIFO. It decodes host command bytes and controls the backlight and frame window. During a memory-write frame it forwards pixel bytes to an external write FIFO with a one-cycle write enable and a FIFO write clock. It sits between the host MCU pins and the RGB timing generator's pixel FIFO, and runs entirely in the CLK domain.

Parameters:
H_RES, 800, active pixels per line
V_RES, 480, active lines per frame
BYTES_PER_PIXEL, 2, bus bytes per pixel (RGB565 over 8-bit bus)

Ports:
CLK  in  1  system clock; all logic rising-edge
nRST  in  1  asynchronous active-low reset
J80_CLK  in  1  host write strobe; asynchronous; a byte is taken on its rising edge
J80_RS  in  1  0 = command byte, 1 = data byte
J80_We  in  1  write enable; a strobe is ignored unless this is 1
J80_Re  out  1  ready: 1 = idle and able to accept a byte
J80_Data  in  8  host byte
FIFOWe  out  1  one-CLK pixel-byte write enable to the FIFO
FIFO_WClk  out  1  FIFO write clock; rises one CLK after FIFOWe rises
LCD_BL  out  1  backlight enable
FrameCtrl  out  1  1 while a memory-write frame is open
RGBData  out  8  pixel byte to the FIFO

Behaviour:
- Reset (nRST=0, async): every register 0; J80_Re=0, FIFOWe=0, FIFO_WClk=0, LCD_BL=0, FrameCtrl=0, RGBData=0, byte counter 0. J80_Re goes to 1 on the first CLK after reset release. A reset mid-frame aborts the frame with no partial output.
- Input sync: J80_CLK, J80_RS, J80_We and J80_Data each pass through a 2-flop synchronizer. A rising-edge detect on the synchronized J80_CLK produces the internal strobe, 3 CLK after the pin edge.
- Host timing: J80_CLK high ≥2 CLK and low ≥2 CLK. RS, We and Data stable from ≥2 CLK before the J80_CLK rise until ≥3 CLK after it.
- Strobe with We=0: ignored.
- Strobe with We=1, RS=0 (command):
  - 0x29: LCD_BL=1.
  - 0x28: LCD_BL=0.
  - 0x2C: FrameCtrl=1; byte counter cleared.
  - 0x01: soft reset; LCD_BL=0, FrameCtrl=0, counter cleared.
  - Any other command (e.g. 0x60): no output change.
  - Any command other than 0x2C also closes an open frame (FrameCtrl=0).
- Strobe with We=1, RS=1 (data):
  - Frame open: the cycle after the strobe, RGBData=byte and FIFOWe=1 for exactly 1 CLK. FIFO_WClk=1 on the next CLK for 1 CLK. Counter increments.
  - Frame closed: byte dropped; no FIFOWe.
- Frame end: when the counter reaches H_RES*V_RES*BYTES_PER_PIXEL, FrameCtrl=0 on the same cycle as the last FIFOWe. Further data bytes are dropped until the next 0x2C.
- J80_Re is 0 from the strobe cycle through the FIFO_WClk cycle (3 CLK), otherwise 1.
- RGBData holds its last value between writes.
- Counter width is clog2(H_RES*V_RES*BYTES_PER_PIXEL+1); it never wraps.

Decomposition:
- Shared package: command codes CMD_SWRESET=0x01, CMD_DISPOFF=0x28, CMD_DISPON=0x29, CMD_RAMWR=0x2C; the frame byte-count function.
- One sub-module, j80_sync: generic-width 2-flop synchronizer plus rising-edge detect, instantiated for the strobe and the bus bundle.

Test Plan:
- Reset held 100 ns, then released → all outputs 0; J80_Re=1 one CLK after release.
- 20 command strobes of 0x60 (RS=0, We=1, 40 ns high / 40 ns low) → FIFOWe never asserts; LCD_BL=0, FrameCtrl=0, RGBData=0.
- Command 0x29, then 0x28 → LCD_BL rises 4 CLK after the first strobe edge, then falls after the second.
- Command 0x2C, then data bytes 0xA5 and 0x3C → FrameCtrl=1; two 1-CLK FIFOWe pulses with RGBData=0xA5 then 0x3C; FIFO_WClk pulses 1 CLK after each FIFOWe.
- Data byte 0x55 with no 0x2C, and a strobe with We=0 → no FIFOWe; RGBData unchanged.
- H_RES=2, V_RES=1: send 0x2C, then 5 data bytes → exactly 4 FIFOWe pulses; FrameCtrl falls with the 4th; the 5th byte is dropped.
